// File: rtl/bcd_display_scanner.sv
// Multiplexed common-anode seven-segment driver: shadow-latches packed BCD digits,
// scans one digit per refresh slot with an anti-ghost blank gap and leading-zero suppression.
module bcd_display_scanner #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int BLANK_CYCLES   = 1,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1,
    parameter int BLANK_LEADING  = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);
    localparam int RCW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDXW = $clog2(NUM_DIGITS);

    localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF  = (SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? '1 : '0;

    logic [NUM_DIGITS-1:0][3:0] shadow_q;
    logic [NUM_DIGITS-1:0]      sdp_q;
    logic [RCW-1:0]             rc_q, rc_d;
    logic [IDXW-1:0]            idx_q, idx_d;
    logic [6:0]                 seg_q, seg_d;
    logic                       dp_q, dp_d;
    logic [NUM_DIGITS-1:0]      an_q, an_d;
    logic                       fd_q, fd_d;

    logic [NUM_DIGITS-1:0] lz;
    logic                  zrun;
    logic [6:0]            seg_raw;
    logic [NUM_DIGITS-1:0] onehot;
    logic                  slot_end, blank_digit;

    function automatic logic [6:0] bcd7(input logic [3:0] v);
        case (v)
            4'd0:    bcd7 = 7'h3F;
            4'd1:    bcd7 = 7'h06;
            4'd2:    bcd7 = 7'h5B;
            4'd3:    bcd7 = 7'h4F;
            4'd4:    bcd7 = 7'h66;
            4'd5:    bcd7 = 7'h6D;
            4'd6:    bcd7 = 7'h7D;
            4'd7:    bcd7 = 7'h07;
            4'd8:    bcd7 = 7'h7F;
            4'd9:    bcd7 = 7'h6F;
            default: bcd7 = 7'h40;
        endcase
    endfunction

    // lz[i]: digits i..top are all zero with no dp set, so digit i is a leading zero
    always_comb begin
        zrun = 1'b1;
        lz   = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zrun  = zrun && (shadow_q[i] == 4'd0) && !sdp_q[i];
            lz[i] = zrun;
        end
    end

    always_comb begin
        slot_end    = (rc_q == RCW'(REFRESH_DIV - 1));
        rc_d        = slot_end ? '0 : rc_q + 1'b1;
        idx_d       = idx_q;
        fd_d        = 1'b0;
        if (slot_end) begin
            if (idx_q == IDXW'(NUM_DIGITS - 1)) begin
                idx_d = '0;
                fd_d  = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end

        onehot      = NUM_DIGITS'(1) << idx_q;
        blank_digit = (BLANK_LEADING != 0) && (idx_q != '0) && lz[idx_q];
        seg_raw     = blank_digit ? 7'h00 : bcd7(shadow_q[idx_q]);

        seg_d = seg_q;
        dp_d  = dp_q;
        an_d  = (AN_ACTIVE_LOW != 0) ? ~onehot : onehot;
        if (rc_q < RCW'(BLANK_CYCLES)) begin
            seg_d = SEG_OFF;
            dp_d  = DP_OFF;
            an_d  = AN_OFF;
        end else if (rc_q == RCW'(BLANK_CYCLES)) begin
            // Segment data is frozen here so a mid-slot load waits for the next slot
            seg_d = (SEG_ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
            dp_d  = sdp_q[idx_q] ^ DP_OFF;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q <= '0;
            sdp_q    <= '0;
            rc_q     <= '0;
            idx_q    <= '0;
            seg_q    <= SEG_OFF;
            dp_q     <= DP_OFF;
            an_q     <= AN_OFF;
            fd_q     <= 1'b0;
        end else begin
            if (load) begin
                shadow_q <= bcd_in;
                sdp_q    <= dp_in;
            end
            rc_q  <= rc_d;
            idx_q <= idx_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
            an_q  <= an_d;
            fd_q  <= fd_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_done = fd_q;
endmodule

// File: tb/tb_bcd_display_scanner.sv
// Scoreboard bench: driver pushes expected outputs from a time-based display model,
// monitor pops and compares one entry after every clock edge.
module tb_bcd_display_scanner;
    localparam int N   = 4;
    localparam int DIV = 4;
    localparam int BLK = 1;

    logic           clk = 1'b0;
    logic           reset, load;
    logic [4*N-1:0] bcd_in;
    logic [N-1:0]   dp_in;
    logic [6:0]     seg;
    logic           dp;
    logic [N-1:0]   an;
    logic           frame_done;

    always #5 clk = ~clk;

    bcd_display_scanner #(
        .NUM_DIGITS(N), .REFRESH_DIV(DIV), .BLANK_CYCLES(BLK),
        .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1), .BLANK_LEADING(1)
    ) dut (
        .clk(clk), .reset(reset), .bcd_in(bcd_in), .dp_in(dp_in), .load(load),
        .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
    );

    typedef struct packed {
        logic [6:0]   seg;
        logic         dp;
        logic [N-1:0] an;
        logic         fd;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: t = cycles since reset; the slot and digit follow by division
    int         t = 0;
    logic [3:0] sd[N] = '{default: 4'd0};
    logic [N-1:0] sdp = '0;
    logic [6:0] snap_seg = 7'h00;
    logic       snap_dp  = 1'b0;
    logic [6:0] LUT[16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

    task automatic cyc(input logic r, input logic l, input logic [4*N-1:0] b, input logic [N-1:0] d);
        exp_t e;
        int   pos, idx, msd;
        reset = r; load = l; bcd_in = b; dp_in = d;
        e = '{seg: 7'h7F, dp: 1'b1, an: {N{1'b1}}, fd: 1'b0};
        if (!r) begin
            pos  = t % DIV;
            idx  = (t / DIV) % N;
            e.fd = (pos == DIV - 1) && (idx == N - 1);
            if (pos >= BLK) begin
                e.an = ~(N'(1) << idx);
                if (pos == BLK) begin
                    msd = 0;
                    for (int j = 0; j < N; j++) if (sd[j] != 4'd0 || sdp[j]) msd = j;
                    snap_seg = (idx > msd) ? 7'h00 : LUT[sd[idx]];
                    snap_dp  = sdp[idx];
                end
                e.seg = ~snap_seg;
                e.dp  = ~snap_dp;
            end
        end
        q.push_back(e);
        if (r) begin
            t = 0; sdp = '0;
            for (int j = 0; j < N; j++) sd[j] = 4'd0;
        end else begin
            t++;
            if (l) begin
                for (int j = 0; j < N; j++) sd[j] = b[4*j +: 4];
                sdp = d;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 16'h0, 4'h0);
    endtask

    task automatic chk(input string name, input logic [6:0] got, input logic [6:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %h expected %h", name, $time, got, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("seg", seg, e.seg);
                chk("dp", {6'b0, dp}, {6'b0, e.dp});
                chk("an", {3'b0, an}, {3'b0, e.an});
                chk("frame_done", {6'b0, frame_done}, {6'b0, e.fd});
            end
        end
    end

    initial begin : driver
        logic [4*N-1:0] rb;
        logic [N-1:0]   rd;
        cyc(1'b1, 1'b0, 16'h0, 4'h0);
        cyc(1'b1, 1'b0, 16'h0, 4'h0);
        cyc(1'b1, 1'b0, 16'h0, 4'h0);
        idle(20);
        cyc(1'b0, 1'b1, 16'h1234, 4'h0); idle(20);
        cyc(1'b0, 1'b1, 16'h0007, 4'h0); idle(20);
        cyc(1'b0, 1'b1, 16'h0000, 4'h0); idle(20);
        cyc(1'b0, 1'b1, 16'h00A5, 4'b0100); idle(20);
        // load inside the digit1 slot at rc=2
        while (t % (DIV * N) != DIV + 2) idle(1);
        cyc(1'b0, 1'b1, 16'h9999, 4'h0); idle(20);
        // reset with simultaneous load mid digit2 slot
        while (t % (DIV * N) != 2 * DIV + 2) idle(1);
        cyc(1'b1, 1'b1, 16'h5555, 4'hF); idle(20);
        for (int i = 0; i < 400; i++) begin
            for (int j = 0; j < N; j++)
                rb[4*j +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            rd = ($urandom_range(0, 5) == 0) ? N'(1) << $urandom_range(0, N - 1) : '0;
            cyc(($urandom_range(0, 79) == 0), ($urandom_range(0, 5) == 0), rb, rd);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d left expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
